// File: rtl/chirp_window_scheduler.sv
// Per-chirp sequencer: FFT reset, next strobe, sample-pair streaming, FFT gap, frame count.
// Optional SCHED_OVERRUN_CNT_EN adds a saturating overrun counter port.
module chirp_window_scheduler #(
    parameter int NUM_PAIRS        = 1024,
    parameter int ADDR_W           = 11,
    parameter int GAP_CYCLES       = 11290,
    parameter int CHIRPS_PER_FRAME = 64,
    parameter int CHIRP_W          = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               chirp_start,
    input  logic               smp_ack,
    input  logic               fft_done,
    output logic               fft_reset,
    output logic               next,
    output logic               smp_req,
    output logic [ADDR_W-1:0]  win_addr,
    output logic               busy,
    output logic [CHIRP_W-1:0] chirp_idx,
    output logic               frame_done,
    output logic               overrun
`ifdef SCHED_OVERRUN_CNT_EN
    ,
    output logic [7:0]         overrun_cnt
`endif
);

    localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RST0,
        RST1,
        NXT0,
        NXT1,
        STREAM,
        GAP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PW-1:0]      pair_q;
    logic [PW-1:0]      pair_d;
    logic [GW-1:0]      gap_q;
    logic [GW-1:0]      gap_d;
    logic [CHIRP_W-1:0] idx_d;
    logic               frame_done_d;
    logic               overrun_d;

    always_comb begin
        state_d      = state_q;
        pair_d       = pair_q;
        gap_d        = gap_q;
        idx_d        = chirp_idx;
        frame_done_d = 1'b0;
        overrun_d    = chirp_start && (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (enable && chirp_start)
                    state_d = RST0;
            end
            RST0:   state_d = RST1;
            RST1:   state_d = NXT0;
            NXT0:   state_d = NXT1;
            NXT1:   state_d = STREAM;
            STREAM: begin
                if (smp_req && smp_ack) begin
                    if (pair_q == PW'(NUM_PAIRS - 1)) begin
                        pair_d  = '0;
                        state_d = GAP;
                    end else begin
                        pair_d = pair_q + 1'b1;
                    end
                end
            end
            GAP: begin
                // Either the FFT reports completion or the worst-case gap elapses
                if (gap_q == GW'(GAP_CYCLES - 1) || fft_done) begin
                    gap_d   = '0;
                    state_d = IDLE;
                    if (chirp_idx == CHIRP_W'(CHIRPS_PER_FRAME - 1)) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = chirp_idx + 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they align with state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pair_q     <= '0;
            gap_q      <= '0;
            fft_reset  <= 1'b0;
            next       <= 1'b0;
            smp_req    <= 1'b0;
            win_addr   <= '0;
            busy       <= 1'b0;
            chirp_idx  <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pair_q     <= pair_d;
            gap_q      <= gap_d;
            fft_reset  <= (state_d == RST0) || (state_d == RST1);
            next       <= (state_d == NXT0) || (state_d == NXT1);
            smp_req    <= (state_d == STREAM);
            win_addr   <= ADDR_W'({pair_d, 1'b0});
            busy       <= (state_d != IDLE);
            chirp_idx  <= idx_d;
            frame_done <= frame_done_d;
            overrun    <= overrun_d;
        end
    end

`ifdef SCHED_OVERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_cnt <= '0;
        end else if (frame_done_d) begin
            overrun_cnt <= overrun_d ? 8'd1 : 8'd0;
        end else if (overrun_d && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_chirp_window_scheduler.sv
// Scoreboard bench for chirp_window_scheduler (reduced geometry for run time).
module tb_chirp_window_scheduler;

    localparam int NP  = 32;
    localparam int AW  = 6;
    localparam int GC  = 200;
    localparam int CPF = 8;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          chirp_start;
    logic          smp_ack;
    logic          fft_done;
    logic          fft_reset;
    logic          next;
    logic          smp_req;
    logic [AW-1:0] win_addr;
    logic          busy;
    logic [CW-1:0] chirp_idx;
    logic          frame_done;
    logic          overrun;
`ifdef SCHED_OVERRUN_CNT_EN
    logic [7:0]    overrun_cnt;
`endif

    chirp_window_scheduler #(
        .NUM_PAIRS(NP),
        .ADDR_W(AW),
        .GAP_CYCLES(GC),
        .CHIRPS_PER_FRAME(CPF),
        .CHIRP_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .chirp_start(chirp_start),
        .smp_ack(smp_ack),
        .fft_done(fft_done),
        .fft_reset(fft_reset),
        .next(next),
        .smp_req(smp_req),
        .win_addr(win_addr),
        .busy(busy),
        .chirp_idx(chirp_idx),
        .frame_done(frame_done),
        .overrun(overrun)
`ifdef SCHED_OVERRUN_CNT_EN
        ,
        .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int            total  = 0;
    int            passed = 0;
    logic [AW-1:0] exp_addr[$];
    int            exp_idx;
    logic          exp_fd;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_chirp();
        for (int i = 0; i < NP; i++) exp_addr.push_back(AW'(2 * i));
    endtask

    function automatic void model_gap_exit();
        exp_fd = (exp_idx == CPF - 1);
        exp_idx = exp_fd ? 0 : exp_idx + 1;
    endfunction

    // Runs one chirp to its first GAP cycle; errors are reported to the caller
    task automatic do_chirp(input int ack_pct, input bit rnd_done,
                            input int drop_at, output int xfers,
                            output int err);
        int n;
        bit seen;
        bit ack;
        logic [AW-1:0] e;
        n = 0;
        seen = 0;
        xfers = 0;
        err = 0;
        push_chirp();
        chirp_start = 1'b1;
        step();
        chirp_start = 1'b0;
        while (n < 50 * NP) begin
            if (smp_req) seen = 1;
            else if (seen) break;
            if (xfers == drop_at) enable = 1'b0;
            ack = ($urandom_range(99) < ack_pct);
            smp_ack = ack;
            fft_done = rnd_done ? 1'($urandom_range(1)) : 1'b0;
            if (smp_req && ack) begin
                xfers++;
                if (exp_addr.size() == 0) err++;
                else begin
                    e = exp_addr.pop_front();
                    if (win_addr !== e) err++;
                end
            end
            step();
            n++;
        end
        smp_ack = 1'b0;
        fft_done = 1'b0;
        if (!seen || n >= 50 * NP) err++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        chirp_start = 1'b0;
        smp_ack = 1'b0;
        fft_done = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (10) step();
        total++;
        if ({fft_reset, next, smp_req, frame_done, overrun} !== 5'b0)
            $display("FAIL reset_strobes got=%b exp=0",
                     {fft_reset, next, smp_req, frame_done, overrun});
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy);
        else passed++;
        total++;
        if (win_addr !== '0 || chirp_idx !== '0)
            $display("FAIL reset_addr_idx got=%0d/%0d exp=0/0", win_addr, chirp_idx);
        else passed++;
        exp_idx = 0;
    endtask

    task automatic test_latency_and_gap();
        int k;
        logic [AW-1:0] e;
        enable = 1'b1;
        smp_ack = 1'b1;
        push_chirp();
        chirp_start = 1'b1;
        step();
        chirp_start = 1'b0;
        total++;
        if ({fft_reset, next, smp_req, busy} !== 4'b1001)
            $display("FAIL lat_n1 got=%b exp=1001", {fft_reset, next, smp_req, busy});
        else passed++;
        step();
        total++;
        if ({fft_reset, next, smp_req} !== 3'b100)
            $display("FAIL lat_n2 got=%b exp=100", {fft_reset, next, smp_req});
        else passed++;
        step();
        total++;
        if ({fft_reset, next, smp_req} !== 3'b010)
            $display("FAIL lat_n3 got=%b exp=010", {fft_reset, next, smp_req});
        else passed++;
        step();
        total++;
        if ({fft_reset, next, smp_req} !== 3'b010)
            $display("FAIL lat_n4 got=%b exp=010", {fft_reset, next, smp_req});
        else passed++;
        for (int i = 0; i < NP; i++) begin
            step();
            e = exp_addr.pop_front();
            total++;
            if (smp_req !== 1'b1 || win_addr !== e)
                $display("FAIL stream_addr got=%b/%0d exp=1/%0d", smp_req, win_addr, e);
            else passed++;
        end
        step();
        smp_ack = 1'b0;
        total++;
        if ({smp_req, busy} !== 2'b01 || win_addr !== '0)
            $display("FAIL stream_end got=%b/%0d exp=01/0", {smp_req, busy}, win_addr);
        else passed++;
        k = 0;
        while (busy && k < GC + 10) begin
            step();
            k++;
        end
        model_gap_exit();
        total++;
        if (k !== GC) $display("FAIL gap_timeout got=%0d exp=%0d", k, GC);
        else passed++;
        total++;
        if (chirp_idx !== CW'(exp_idx) || frame_done !== exp_fd)
            $display("FAIL gap_idx got=%0d/%b exp=%0d/%b",
                     chirp_idx, frame_done, exp_idx, exp_fd);
        else passed++;
    endtask

    task automatic test_stalls_and_done();
        int x;
        int err;
        do_chirp(50, 1'b1, -1, x, err);
        total++;
        if (x !== NP || err !== 0 || exp_addr.size() !== 0)
            $display("FAIL stall_stream got=%0d xfers %0d errs exp=%0d/0", x, err, NP);
        else passed++;
        repeat (100) step();
        total++;
        if (busy !== 1'b1) $display("FAIL gap_hold got=%b exp=1", busy);
        else passed++;
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        model_gap_exit();
        total++;
        if (busy !== 1'b0 || chirp_idx !== CW'(exp_idx))
            $display("FAIL gap_done got=%b/%0d exp=0/%0d", busy, chirp_idx, exp_idx);
        else passed++;
    endtask

    task automatic test_overrun();
        int n;
        int x;
        int ov;
        bit seen;
        bit inj;
        logic [AW-1:0] e;
        n = 0;
        x = 0;
        ov = 0;
        seen = 0;
        inj = 0;
        push_chirp();
        smp_ack = 1'b1;
        chirp_start = 1'b1;
        step();
        chirp_start = 1'b0;
        while (n < 10 * NP) begin
            if (overrun) ov++;
            if (smp_req) seen = 1;
            else if (seen) break;
            chirp_start = (smp_req && x == 5 && !inj);
            if (chirp_start) inj = 1;
            if (smp_req) begin
                x++;
                e = exp_addr.pop_front();
                total++;
                if (win_addr !== e)
                    $display("FAIL ovr_addr got=%0d exp=%0d", win_addr, e);
                else passed++;
            end
            step();
            n++;
        end
        chirp_start = 1'b0;
        smp_ack = 1'b0;
        total++;
        if (ov !== 1 || x !== NP)
            $display("FAIL overrun_pulse got=%0d pulses %0d xfers exp=1/%0d", ov, x, NP);
        else passed++;
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        model_gap_exit();
        total++;
        if (busy !== 1'b0 || chirp_idx !== CW'(exp_idx))
            $display("FAIL overrun_idx got=%b/%0d exp=0/%0d", busy, chirp_idx, exp_idx);
        else passed++;
    endtask

`ifdef SCHED_OVERRUN_CNT_EN
    task automatic test_overrun_cnt();
        int n;
        push_chirp();
        smp_ack = 1'b0;
        chirp_start = 1'b1;
        repeat (305) step();
        chirp_start = 1'b0;
        step();
        total++;
        if (overrun_cnt !== 8'd255)
            $display("FAIL overrun_sat got=%0d exp=255", overrun_cnt);
        else passed++;
        smp_ack = 1'b1;
        n = 0;
        while (smp_req && n < 2 * NP) begin
            void'(exp_addr.pop_front());
            step();
            n++;
        end
        smp_ack = 1'b0;
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        model_gap_exit();
        total++;
        if (n !== NP || chirp_idx !== CW'(exp_idx))
            $display("FAIL overrun_cnt_chirp got=%0d/%0d exp=%0d/%0d",
                     n, chirp_idx, NP, exp_idx);
        else passed++;
    endtask
`endif

    task automatic test_frame();
        int x;
        int err;
        int fds;
        fds = 0;
        for (int c = 0; c < CPF; c++) begin
            do_chirp(100, 1'b0, -1, x, err);
            fft_done = 1'b1;
            step();
            fft_done = 1'b0;
            model_gap_exit();
            if (frame_done) fds++;
            total++;
            if (err !== 0 || chirp_idx !== CW'(exp_idx) || frame_done !== exp_fd)
                $display("FAIL frame_chirp got=%0d/%b errs=%0d exp=%0d/%b",
                         chirp_idx, frame_done, err, exp_idx, exp_fd);
            else passed++;
`ifdef SCHED_OVERRUN_CNT_EN
            if (exp_fd) begin
                total++;
                if (overrun_cnt !== 8'd0)
                    $display("FAIL overrun_clear got=%0d exp=0", overrun_cnt);
                else passed++;
            end
`endif
        end
        step();
        total++;
        if (fds !== 1 || frame_done !== 1'b0)
            $display("FAIL frame_count got=%0d/%b exp=1/0", fds, frame_done);
        else passed++;
    endtask

    task automatic test_enable_drop();
        int x;
        int err;
        int k;
        do_chirp(100, 1'b0, 10, x, err);
        total++;
        if (x !== NP || err !== 0)
            $display("FAIL drop_stream got=%0d/%0d exp=%0d/0", x, err, NP);
        else passed++;
        k = 0;
        while (busy && k < GC + 10) begin
            step();
            k++;
        end
        model_gap_exit();
        total++;
        if (k !== GC || chirp_idx !== CW'(exp_idx))
            $display("FAIL drop_gap got=%0d/%0d exp=%0d/%0d", k, chirp_idx, GC, exp_idx);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            chirp_start = 1'b1;
            step();
            chirp_start = 1'b0;
            step();
            total++;
            if (busy !== 1'b0 || overrun !== 1'b0 || fft_reset !== 1'b0)
                $display("FAIL drop_ignore got=%b exp=000", {busy, overrun, fft_reset});
            else passed++;
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        int x;
        int err;
        push_chirp();
        smp_ack = 1'b1;
        chirp_start = 1'b1;
        step();
        chirp_start = 1'b0;
        repeat (12) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        smp_ack = 1'b0;
        exp_addr.delete();
        exp_idx = 0;
        total++;
        if ({fft_reset, next, smp_req, busy, frame_done, overrun} !== 6'b0 ||
            win_addr !== '0 || chirp_idx !== '0)
            $display("FAIL reset_mid got=%b/%0d/%0d exp=0",
                     {fft_reset, next, smp_req, busy, frame_done, overrun},
                     win_addr, chirp_idx);
        else passed++;
        step();
        total++;
        if ({fft_reset, next, busy} !== 3'b0)
            $display("FAIL reset_glitch got=%b exp=000", {fft_reset, next, busy});
        else passed++;
        do_chirp(70, 1'b0, -1, x, err);
        fft_done = 1'b1;
        step();
        fft_done = 1'b0;
        model_gap_exit();
        total++;
        if (err !== 0 || chirp_idx !== CW'(exp_idx))
            $display("FAIL reset_recover got=%0d/%0d exp=0/%0d", err, chirp_idx, exp_idx);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_latency_and_gap();
        test_stalls_and_done();
        test_overrun();
`ifdef SCHED_OVERRUN_CNT_EN
        test_overrun_cnt();
`endif
        test_frame();
        test_enable_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
